// File: rtl/iob_clint_mh.sv
// rtl/iob_clint_mh.sv - multi-hart core-local interruptor (MTIMER + MSWI) on the native valid/ready bus
module iob_clint_mh #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int N_CORES  = 1,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [15:0] MTIME_LO = 16'hBFF8;
    localparam logic [15:0] MTIME_HI = 16'hBFFC;

    // Word-aligned offset; the two byte-select bits are don't-care.
    logic [15:0] offset;
    logic        unused_addr;
    assign offset      = {address[15:2], 2'b00};
    assign unused_addr = ^{address, 1'b0};

    // A transaction with any strobe set is a write; all-zero strobes are reads.
    logic write;
    assign write = valid & (|wstrb);

    // Region decode: 0x0000-0x3FFF msip words, 0x4000-0x7FFF mtimecmp pairs.
    logic        in_msip;
    logic        in_cmp;
    logic [11:0] msip_idx;
    logic [10:0] cmp_idx;
    logic        cmp_hi;
    logic        hit_time_lo;
    logic        hit_time_hi;

    assign in_msip     = (offset[15:14] == 2'b00);
    assign in_cmp      = (offset[15:14] == 2'b01);
    assign msip_idx    = offset[13:2];
    assign cmp_idx     = offset[13:3];
    assign cmp_hi      = offset[2];
    assign hit_time_lo = (offset == MTIME_LO);
    assign hit_time_hi = (offset == MTIME_HI);

    // Byte-lane merge of a write into an existing 32-bit word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    logic [PS_W-1:0] ps_count;
    logic            tick;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp [N_CORES];
    logic            ready_q;
    logic [31:0]     rd_word;

    assign tick = (ps_count == PS_LAST);

    // Prescaler: free-running 0..PRESCALE-1; mtime writes do not disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_count <= '0;
        end else if (tick) begin
            ps_count <= '0;
        end else begin
            ps_count <= ps_count + PS_W'(1);
        end
    end

    // mtime: a bus write wins over the tick, so the increment is dropped that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= 64'd0;
        end else if (write && hit_time_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wstrb);
        end else if (write && hit_time_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Per-hart compare registers, written a 32-bit half at a time.
    always_ff @(posedge clk) begin
        for (int h = 0; h < N_CORES; h++) begin
            if (reset) begin
                mtimecmp[h] <= {64{1'b1}};
            end else if (write && in_cmp && (cmp_idx == 11'(h))) begin
                if (cmp_hi) begin
                    mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
                end else begin
                    mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
                end
            end
        end
    end

    // Software interrupt bits; only byte lane 0 carries the writable bit.
    always_ff @(posedge clk) begin
        for (int h = 0; h < N_CORES; h++) begin
            if (reset) begin
                msip[h] <= 1'b0;
            end else if (write && in_msip && (msip_idx == 12'(h)) && wstrb[0]) begin
                msip[h] <= wdata[0];
            end
        end
    end

    // Timer interrupt: registered unsigned compare of the current register values.
    always_ff @(posedge clk) begin
        for (int h = 0; h < N_CORES; h++) begin
            if (reset) begin
                mtip[h] <= 1'b0;
            end else begin
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    // Read mux over pre-update register contents; unmapped offsets read zero.
    always_comb begin
        rd_word = 32'd0;
        if (in_msip) begin
            for (int h = 0; h < N_CORES; h++) begin
                if (msip_idx == 12'(h)) begin
                    rd_word = {31'd0, msip[h]};
                end
            end
        end else if (in_cmp) begin
            for (int h = 0; h < N_CORES; h++) begin
                if (cmp_idx == 11'(h)) begin
                    rd_word = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
                end
            end
        end else if (hit_time_lo) begin
            rd_word = mtime[31:0];
        end else if (hit_time_hi) begin
            rd_word = mtime[63:32];
        end
    end

    // Bus response: one ready per valid cycle, rdata captured with the request and held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata   <= '0;
        end else begin
            ready_q <= valid;
            if (valid) begin
                rdata <= rd_word;
            end
        end
    end

    // A reset arriving while a response is pending suppresses that response.
    assign ready = ready_q & ~reset;

endmodule

// File: tb/tb_iob_clint_mh.sv
// tb/tb_iob_clint_mh.sv - self-checking bench for iob_clint_mh (PRESCALE=1 and PRESCALE=4 instances)
module tb_iob_clint_mh;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        b_valid [2];
    logic [15:0] b_addr  [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_wstrb [2];
    logic [31:0] o_rdata [2];
    logic        o_ready [2];
    logic [1:0]  o_mtip  [2];
    logic [1:0]  o_msip  [2];

    int total = 0;
    int bad   = 0;

    iob_clint_mh #(.ADDR_W(16), .DATA_W(32), .N_CORES(2), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .valid(b_valid[0]), .address(b_addr[0]), .wdata(b_wdata[0]),
        .wstrb(b_wstrb[0]), .rdata(o_rdata[0]), .ready(o_ready[0]), .mtip(o_mtip[0]), .msip(o_msip[0])
    );

    iob_clint_mh #(.ADDR_W(16), .DATA_W(32), .N_CORES(2), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .valid(b_valid[1]), .address(b_addr[1]), .wdata(b_wdata[1]),
        .wstrb(b_wstrb[1]), .rdata(o_rdata[1]), .ready(o_ready[1]), .mtip(o_mtip[1]), .msip(o_msip[1])
    );

    // ---------------- reference model ----------------
    int          m_cyc  [2];
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2][2];
    logic [1:0]  m_msip [2];
    logic [1:0]  m_mtip [2];
    logic [31:0] m_rd   [2];

    function automatic int ps_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] st);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [15:0] a);
        int o;
        int h;
        o = int'({a[15:2], 2'b00});
        if (o < 'h4000) begin
            h = o / 4;
            if (h < 2) return {31'd0, m_msip[d][h]};
        end else if (o < 'h8000) begin
            h = (o - 'h4000) / 8;
            if (h < 2) return (o % 8 == 4) ? m_cmp[d][h][63:32] : m_cmp[d][h][31:0];
        end else if (o == 'hBFF8) begin
            return m_time[d][31:0];
        end else if (o == 'hBFFC) begin
            return m_time[d][63:32];
        end
        return 32'd0;
    endfunction

    always @(posedge clk) begin : model
        logic [1:0]  nm;
        logic [63:0] nt;
        int          o;
        int          h;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_cyc[d]  = 0;
                m_time[d] = 64'd0;
                m_cmp[d][0] = '1;
                m_cmp[d][1] = '1;
                m_msip[d] = 2'b00;
                m_mtip[d] = 2'b00;
                m_rd[d]   = 32'd0;
            end else begin
                for (int k = 0; k < 2; k++) nm[k] = (m_time[d] >= m_cmp[d][k]);
                nt = ((m_cyc[d] % ps_of(d)) == ps_of(d) - 1) ? m_time[d] + 64'd1 : m_time[d];
                if (b_valid[d]) begin
                    m_rd[d] = m_read(d, b_addr[d]);
                    if (b_wstrb[d] != 4'h0) begin
                        o = int'({b_addr[d][15:2], 2'b00});
                        if (o == 'hBFF8) begin
                            nt = {m_time[d][63:32], merge(m_time[d][31:0], b_wdata[d], b_wstrb[d])};
                        end else if (o == 'hBFFC) begin
                            nt = {merge(m_time[d][63:32], b_wdata[d], b_wstrb[d]), m_time[d][31:0]};
                        end else if (o < 'h4000) begin
                            h = o / 4;
                            if (h < 2 && b_wstrb[d][0]) m_msip[d][h] = b_wdata[d][0];
                        end else if (o < 'h8000) begin
                            h = (o - 'h4000) / 8;
                            if (h < 2) begin
                                if (o % 8 == 4) m_cmp[d][h][63:32] = merge(m_cmp[d][h][63:32], b_wdata[d], b_wstrb[d]);
                                else            m_cmp[d][h][31:0]  = merge(m_cmp[d][h][31:0],  b_wdata[d], b_wstrb[d]);
                            end
                        end
                    end
                end
                m_time[d] = nt;
                m_mtip[d] = nm;
                m_cyc[d]  = m_cyc[d] + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input int d, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic rdy);
        b_valid[d] = 1'b1;
        b_addr[d]  = a;
        b_wdata[d] = wd;
        b_wstrb[d] = st;
        @(posedge clk);
        @(negedge clk);
        b_valid[d] = 1'b0;
        b_wstrb[d] = 4'h0;
        rd  = o_rdata[d];
        rdy = o_ready[d];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic        rdy;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (o_ready[d] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=0", d, o_ready[d]); end
            total++; if (o_mtip[d] !== 2'b00) begin bad++; $display("FAIL reset_mtip[%0d] got=%b want=00", d, o_mtip[d]); end
            total++; if (o_msip[d] !== 2'b00) begin bad++; $display("FAIL reset_msip[%0d] got=%b want=00", d, o_msip[d]); end
            total++; if (o_rdata[d] !== 32'd0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h want=0", d, o_rdata[d]); end
        end
        reset = 1'b0;
        bus(0, 16'h4000, 32'd0, 4'h0, rd, rdy);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_read_ready got=%b want=1", rdy); end
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp0_lo got=%h want=ffffffff", rd); end
        bus(1, 16'h4004, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp0_hi_b got=%h want=ffffffff", rd); end
    endtask

    task automatic test_mtime_count();
        logic [31:0] r0, r1;
        logic        rdy;
        bus(0, 16'hBFF8, 32'd0, 4'h0, r0, rdy);
        idle(9);
        bus(0, 16'hBFF8, 32'd0, 4'h0, r1, rdy);
        total++; if (r1 - r0 !== 32'd10) begin bad++; $display("FAIL count_ps1 got=%0d want=10", r1 - r0); end
        total++; if (r1 !== m_rd[0]) begin bad++; $display("FAIL count_ps1_model got=%h want=%h", r1, m_rd[0]); end
        bus(1, 16'hBFF8, 32'd0, 4'h0, r0, rdy);
        idle(7);
        bus(1, 16'hBFF8, 32'd0, 4'h0, r1, rdy);
        total++; if (r1 - r0 !== 32'd2) begin bad++; $display("FAIL count_ps4 got=%0d want=2", r1 - r0); end
        total++; if (r1 !== m_rd[1]) begin bad++; $display("FAIL count_ps4_model got=%h want=%h", r1, m_rd[1]); end
    endtask

    task automatic test_tick_write();
        logic [31:0] rd;
        logic        rdy;
        bit          found;
        bus(1, 16'hBFFC, 32'd0, 4'hF, rd, rdy);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if ((m_cyc[1] % 4) == 3) found = 1;
            else @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL tick_align got=none want=tick cycle"); end
        bus(1, 16'hBFF8, 32'd5, 4'hF, rd, rdy);
        bus(1, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd5) begin bad++; $display("FAIL tick_write got=%0d want=5", rd); end
    endtask

    task automatic test_mtip();
        logic [31:0] rd;
        logic        rdy;
        bit          seen;
        bus(0, 16'hBFFC, 32'd0, 4'hF, rd, rdy);
        bus(0, 16'hBFF8, 32'd0, 4'hF, rd, rdy);
        bus(0, 16'h400C, 32'd0, 4'hF, rd, rdy);
        bus(0, 16'h4008, 32'h40, 4'hF, rd, rdy);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            total++; if (o_mtip[0] !== m_mtip[0]) begin bad++; $display("FAIL mtip_track got=%b want=%b", o_mtip[0], m_mtip[0]); end
            if (o_mtip[0][1] === 1'b1) seen = 1;
            else @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL mtip1_rise got=0 want=1 within 200 cycles"); end
        total++; if (o_mtip[0][0] !== 1'b0) begin bad++; $display("FAIL mtip0_quiet got=%b want=0", o_mtip[0][0]); end
        bus(0, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'h41) begin bad++; $display("FAIL mtip1_latency mtime got=%h want=41", rd); end
    endtask

    task automatic test_msip();
        logic [31:0] rd;
        logic        rdy;
        bus(0, 16'h0004, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        total++; if (o_msip[0] !== 2'b10) begin bad++; $display("FAIL msip_set got=%b want=10", o_msip[0]); end
        bus(0, 16'h0004, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd1) begin bad++; $display("FAIL msip_read got=%h want=1", rd); end
        bus(0, 16'h0004, 32'd0, 4'b0010, rd, rdy);
        total++; if (o_msip[0] !== 2'b10) begin bad++; $display("FAIL msip_lane1 got=%b want=10", o_msip[0]); end
        bus(0, 16'h0004, 32'd0, 4'b0001, rd, rdy);
        total++; if (o_msip[0] !== 2'b00) begin bad++; $display("FAIL msip_clear got=%b want=00", o_msip[0]); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        rdy;
        bus(0, 16'h4000, 32'hAABB_CCDD, 4'b0101, rd, rdy);
        bus(0, 16'h4000, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'hFFBB_FFDD) begin bad++; $display("FAIL strobe_merge got=%h want=ffbbffdd", rd); end
        bus(0, 16'h2000, 32'd0, 4'h0, rd, rdy);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL unmapped_ready got=%b want=1", rdy); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_2000 got=%h want=0", rd); end
        bus(0, 16'h4010, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_cmp2 got=%h want=0", rd); end
        bus(0, 16'h0008, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_msip2 got=%h want=0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        rdy;
        for (int i = 0; i < 3; i++) begin
            bus(1, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, rdy); end
            total++; if (rd !== m_rd[1]) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", i, rd, m_rd[1]); end
        end
        idle(1);
        total++; if (o_ready[1] !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", o_ready[1]); end
        total++; if (o_rdata[1] !== m_rd[1]) begin bad++; $display("FAIL rdata_hold got=%h want=%h", o_rdata[1], m_rd[1]); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        rdy;
        bus(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        bus(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, rd, rdy);
        bus(0, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_r0 got=%h want=fffffffe", rd); end
        total++; if (o_mtip[0] !== 2'b11) begin bad++; $display("FAIL wrap_mtip0 got=%b want=11", o_mtip[0]); end
        bus(0, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_r1 got=%h want=ffffffff", rd); end
        total++; if (o_mtip[0] !== 2'b11) begin bad++; $display("FAIL wrap_mtip1 got=%b want=11", o_mtip[0]); end
        bus(0, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL wrap_r2 got=%h want=0", rd); end
        total++; if (o_mtip[0] !== 2'b00) begin bad++; $display("FAIL wrap_mtip_drop got=%b want=00", o_mtip[0]); end
        bus(0, 16'hBFFC, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL wrap_hi got=%h want=0", rd); end
    endtask

    task automatic test_random();
        logic [15:0] tbl [12];
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        rdy;
        int          d;
        tbl = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h2000, 16'hBFF4};
        for (int i = 0; i < 300; i++) begin
            d  = int'($urandom_range(0, 1));
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wd = $urandom;
            bus(d, tbl[$urandom_range(0, 11)], wd, st, rd, rdy);
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=1", i, rdy); end
            if (st == 4'h0) begin
                total++; if (rd !== m_rd[d]) begin bad++; $display("FAIL rand_rdata[%0d] got=%h want=%h", i, rd, m_rd[d]); end
            end
            total++; if (o_mtip[d] !== m_mtip[d]) begin bad++; $display("FAIL rand_mtip[%0d] got=%b want=%b", i, o_mtip[d], m_mtip[d]); end
            total++; if (o_msip[d] !== m_msip[d]) begin bad++; $display("FAIL rand_msip[%0d] got=%b want=%b", i, o_msip[d], m_msip[d]); end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        rdy;
        b_valid[0] = 1'b1;
        b_addr[0]  = 16'hBFF8;
        b_wstrb[0] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        b_valid[0] = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b want=0", o_ready[0]); end
        @(posedge clk);
        @(negedge clk);
        total++; if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL midreset_ready2 got=%b want=0", o_ready[0]); end
        total++; if (o_rdata[0] !== 32'd0) begin bad++; $display("FAIL midreset_rdata got=%h want=0", o_rdata[0]); end
        total++; if (o_mtip[0] !== 2'b00) begin bad++; $display("FAIL midreset_mtip got=%b want=00", o_mtip[0]); end
        reset = 1'b0;
        bus(0, 16'hBFF8, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL midreset_mtime got=%h want=0", rd); end
        bus(0, 16'h4008, 32'd0, 4'h0, rd, rdy);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midreset_cmp1 got=%h want=ffffffff", rd); end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            b_valid[d] = 1'b0;
            b_addr[d]  = 16'h0;
            b_wdata[d] = 32'h0;
            b_wstrb[d] = 4'h0;
        end
        test_reset();
        test_mtime_count();
        test_tick_write();
        test_mtip();
        test_msip();
        test_strobes();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
